// File: rtl/xswitch_up_rx.sv
// rtl/xswitch_up_rx.sv - upstream receive endpoint: dest check, FWFT FIFO, statistics
module xswitch_up_rx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int PORT_ID = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       us_valid,
  input  logic [DATA_W-1:0]          us_data,
  output logic                       us_ready,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           misroute_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              us_ready_q, us_ready_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  misroute_cnt_q, misroute_cnt_d;

  logic xfer, dest_ok, push, misroute, pop;

  // Handshake decode: a completed transfer either lands in the FIFO or is dropped as misrouted
  always_comb begin
    xfer     = us_valid & us_ready_q;
    dest_ok  = (us_data[DATA_W-1:DATA_W-2] == 2'(PORT_ID));
    push     = xfer & dest_ok;
    misroute = xfer & ~dest_ok;
    pop      = rd_en & (level_q != '0);
  end

  // Next-state for storage, pointers, occupancy, ready and saturating counters
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    pkt_cnt_d      = pkt_cnt_q;
    misroute_cnt_d = misroute_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = us_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (pkt_cnt_q != {CNT_W{1'b1}}) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end
    if (misroute && (misroute_cnt_q != {CNT_W{1'b1}})) begin
      misroute_cnt_d = misroute_cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Registered ready looks at the post-edge occupancy so it never depends on rd_en combinationally
    us_ready_d = (level_d != LVL_W'(DEPTH));
  end

  // State registers; reset discards all contents and deasserts ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      us_ready_q     <= 1'b0;
      pkt_cnt_q      <= '0;
      misroute_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      us_ready_q     <= us_ready_d;
      pkt_cnt_q      <= pkt_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end

  // First-word-fall-through read port; forced to zero while empty so stale entries never show
  always_comb begin
    us_ready     = us_ready_q;
    rd_valid     = (level_q != '0);
    rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
    level        = level_q;
    pkt_cnt      = pkt_cnt_q;
    misroute_cnt = misroute_cnt_q;
  end

endmodule

// File: tb/tb_xswitch_up_rx.sv
// tb/tb_xswitch_up_rx.sv - self-checking bench for xswitch_up_rx with queue reference model
module tb_xswitch_up_rx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              us_valid = 1'b0;
  logic [DATA_W-1:0] us_data = '0;
  logic              us_ready;
  logic              rd_en = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        level;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  misroute_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  xswitch_up_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PORT_ID(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .us_valid(us_valid), .us_data(us_data), .us_ready(us_ready),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .pkt_cnt(pkt_cnt), .misroute_cnt(misroute_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus counters, advanced once per rising edge
  byte unsigned m_q[$];
  int           m_pkt = 0;
  int           m_mis = 0;
  bit           m_ready = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_pkt   = 0;
      m_mis   = 0;
      m_ready = 0;
    end else begin
      bit did_pop;
      did_pop = rd_en && (m_q.size() > 0);
      if (us_valid && m_ready) begin
        if (us_data[7:6] == 2'd2) begin
          m_q.push_back(us_data);
          if (m_pkt < (1 << CNT_W) - 1) m_pkt++;
        end else begin
          if (m_mis < (1 << CNT_W) - 1) m_mis++;
        end
      end
      if (did_pop) void'(m_q.pop_front());
      m_ready = (m_q.size() != DEPTH);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    check("model us_ready", int'(us_ready), int'(m_ready));
    check("model rd_valid", int'(rd_valid), int'(m_q.size() > 0));
    check("model level", int'(level), m_q.size());
    check("model pkt_cnt", int'(pkt_cnt), m_pkt);
    check("model misroute_cnt", int'(misroute_cnt), m_mis);
    if (m_q.size() > 0) check("model rd_data", int'(rd_data), int'(m_q[0]));
  end

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    us_valid = v;
    us_data  = d;
    rd_en    = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset us_ready", int'(us_ready), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset rd_data", int'(rd_data), 0);
    check("reset level", int'(level), 0);
    check("reset pkt_cnt", int'(pkt_cnt), 0);
    check("reset misroute_cnt", int'(misroute_cnt), 0);
    reset = 1'b1;
    step(0, 8'h00, 0);
    check("ready after release", int'(us_ready), 1);
    check("rd_valid after release", int'(rd_valid), 0);

    // Ordered fill and drain
    for (int i = 0; i < 4; i++) step(1, 8'h81 + 8'(i), 0);
    check("fill us_ready", int'(us_ready), 0);
    check("fill level", int'(level), 4);
    step(1, 8'h85, 0);
    check("held level", int'(level), 4);
    check("held pkt_cnt", int'(pkt_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      check("drain rd_data", int'(rd_data), 8'h81 + i);
      step(0, 8'h00, 1);
      if (i == 0) check("ready after first pop", int'(us_ready), 1);
    end
    check("drain level", int'(level), 0);
    check("drain pkt_cnt", int'(pkt_cnt), 4);

    // Misroute
    step(1, 8'h41, 0);
    step(1, 8'hC1, 0);
    step(0, 8'h00, 0);
    check("misroute cnt", int'(misroute_cnt), 2);
    check("misroute level", int'(level), 0);
    check("misroute rd_valid", int'(rd_valid), 0);

    // Streaming across wrap with rd_en held
    for (int i = 0; i < 12; i++) begin
      step(1, 8'h80 + 8'(i), 1);
      check("stream level", int'(level), 1);
      check("stream rd_data", int'(rd_data), 8'h80 + i);
      check("stream us_ready", int'(us_ready), 1);
    end
    step(0, 8'h00, 1);
    check("stream pkt_cnt", int'(pkt_cnt), 16);
    check("stream level end", int'(level), 0);

    // Boundary pops
    step(0, 8'h00, 1);
    check("empty pop level", int'(level), 0);
    check("empty pop pkt_cnt", int'(pkt_cnt), 16);
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0);
    check("full level", int'(level), 4);
    step(1, 8'hA4, 1);
    check("full pop level", int'(level), 3);
    check("full pop us_ready", int'(us_ready), 1);
    check("full pop head", int'(rd_data), 8'hA1);

    // Mid-stream reset with level 3
    us_valid = 1'b0;
    rd_en    = 1'b0;
    reset    = 1'b0;
    #1;
    check("midreset level", int'(level), 0);
    check("midreset pkt_cnt", int'(pkt_cnt), 0);
    check("midreset misroute_cnt", int'(misroute_cnt), 0);
    check("midreset rd_valid", int'(rd_valid), 0);
    check("midreset us_ready", int'(us_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 8'h00, 0);
    step(1, 8'h90, 0);
    us_valid = 1'b0;
    check("post reset rd_data", int'(rd_data), 8'h90);
    check("post reset rd_valid", int'(rd_valid), 1);
    check("post reset level", int'(level), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 7) d[7:6] = 2'd2;
      step(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)));
      if (i == 1500) begin
        for (int k = 0; k < 20; k++) step(1, 8'h80 | 8'($urandom_range(0, 63)), 0);
        for (int k = 0; k < 10; k++) step(0, 8'h00, 1);
      end
    end

    us_valid = 1'b0;
    rd_en    = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xswitch_up_rx.md
# xswitch_up_rx

Receive-side endpoint for one upstream (switch output) port of the 4x4 xswitch. Accepts bytes from a switch output over a valid/ready handshake. Checks that each byte's destination field matches its own port, buffers matching bytes in a first-word-fall-through FIFO for a local consumer, and keeps accepted and misrouted counters. One instance sits behind each upstream port, so a switch output always terminates in a real flow-controlled sink.

## Interface
- DATA_W, 8: byte width. Bits [DATA_W-1:DATA_W-2] are the destination port field; the remaining bits are payload.
- DEPTH, 4: FIFO depth in entries. Must be a power of 2, minimum 2.
- PORT_ID, 0: 2-bit port number this instance answers to.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- us_valid  in  1  the switch output presents a byte.
- us_data  in  DATA_W  byte from the switch output.
- us_ready  out  1  sink can take a byte this cycle (registered).
- rd_en  in  1  consumer pops the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_W  head entry; valid only while rd_valid = 1.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- pkt_cnt  out  CNT_W  number of bytes accepted into the FIFO.
- misroute_cnt  out  CNT_W  number of bytes taken with a wrong destination field.

## Operation
- Transfer: a transfer occurs on a clock edge where us_valid = 1 and us_ready = 1.
  - Dest field equals PORT_ID: the byte is written at the write pointer; pkt_cnt increments.
  - Dest field differs: the byte is consumed and discarded (the handshake still completes); misroute_cnt increments; FIFO unchanged.
- Pop: occurs on an edge where rd_en = 1 and rd_valid = 1. The read pointer advances. rd_en while empty is ignored with no side effect.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter, level, in the range 0..DEPTH.
- Simultaneous push and pop:
  - With 0 < level < DEPTH: level is unchanged, both pointers advance, and rd_data shows the next entry.
  - At level = DEPTH: us_ready is 0, so no push occurs; the pop proceeds.
  - At level = 0: rd_valid is 0, so the pop is ignored; the push proceeds.
- Counters saturate at 2^CNT_W-1 and never wrap.
- us_valid with us_ready = 0: the byte is not consumed or counted. The switch holds it.
- Storage is read first-word-fall-through: rd_data is driven combinationally from the head entry.

## Timing
- Reset values, with reset = 0, applied asynchronously:
  - us_ready = 0, rd_valid = 0, rd_data = 0, level = 0.
  - pkt_cnt = 0, misroute_cnt = 0, both pointers = 0.
- Ready after reset: us_ready rises on the first rising clk edge after reset deasserts.
- Ready update: us_ready is a flop loaded each edge with (next_level != DEPTH).
  - It falls on the same edge that fills the last entry.
  - It rises on the edge of the first pop from full.
  - There is no combinational path from rd_en to us_ready.
- Latency: a byte accepted at edge N is visible on rd_data with rd_valid = 1 after edge N, i.e. 1 cycle.
- level, pkt_cnt and misroute_cnt reflect edge N's events immediately after edge N.
- Reset mid-operation: all contents are discarded, and outputs return to their reset values asynchronously. A transfer whose edge coincides with reset assertion is lost and is not counted.
- Throughput: one byte in and one byte out per cycle, sustained, while 0 < level < DEPTH.

## Test plan
All scenarios use PORT_ID=2, DEPTH=4, DATA_W=8.
- Reset: hold reset = 0 for 3 cycles, then release -> all outputs 0 during reset; us_ready = 1 one edge after release; rd_valid = 0.
- Ordered fill and drain: push 0x81, 0x82, 0x83, 0x84 with rd_en = 0 -> us_ready = 0 after the 4th push and level = 4. A 5th us_valid byte (0x85) is held. Then pop 4 times -> rd_data reads 0x81, 0x82, 0x83, 0x84; us_ready = 1 after the first pop; pkt_cnt = 4.
- Misroute: push 0x41 then 0xC1 -> both handshakes complete; misroute_cnt = 2; level = 0; rd_valid stays 0.
- Streaming across wrap: continuous push of 0x80..0x8B with rd_en = 1 held -> level oscillates within 0..1; the output sequence is 0x80..0x8B in order across 3 pointer wraps; no stall.
- Boundary pops: rd_en = 1 while empty -> level stays 0 with no state change. At level = 4, us_valid = 1 and rd_en = 1 -> level = 3 and us_ready = 1 next cycle.
- Mid-stream reset: assert reset with level = 3 -> level, counters and rd_valid go to 0 immediately. After release, push 0x90 -> rd_data = 0x90, not stale data.
